ecg_ram_scheduler: RTL and testbench

- Owns the single port of the ECG sample RAM and shares it between two requesters: the VGA display read path and the ECG sample write path.
- Incoming samples are buffered in a small FIFO and written into a circular region of RAM.
- Display reads have strict priority; writes drain in cycles where the display is not reading.
- At each frame boundary it latches a display base pointer, so each frame shows the most recent WINDOW samples, scrolling cleanly.

---
 rtl/ecg_ram_scheduler.sv | 89 ++++++++
 tb/tb_ecg_ram_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_ram_scheduler.sv
// ecg_ram_scheduler: shares the ECG sample RAM port between display reads (priority) and buffered sample writes.
module ecg_ram_scheduler #(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] RING_BASE = 12'h800,
  parameter int RING_LEN = 2048,
  parameter int WINDOW = 640,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [9:0]        disp_x,
  input  logic              screen_end,
  input  logic              freeze,
  input  logic              smp_valid,
  input  logic [11:0]       smp_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              disp_valid,
  output logic [11:0]       disp_data,
  output logic              fifo_full,
  output logic [15:0]       drop_count
);
  localparam int PW = $clog2(RING_LEN);
  localparam int FW = $clog2(WINDOW + 1);
  localparam int QW = $clog2(FIFO_DEPTH);
  logic [11:0]   fifo [FIFO_DEPTH];
  logic [QW:0]   head, tail, count, count_nxt;
  logic          pop, push;
  logic [PW-1:0] wr_ptr, frame_base, rd_off;
  logic [PW:0]   fill_count;
  logic [FW-1:0] frame_fill;
  logic          p1, p2, b1, b2;
  logic          unused_rdata;
  always_comb begin
    count = tail - head;
    pop = !disp_req && count != '0;
    push = smp_valid && (count < (QW+1)'(FIFO_DEPTH) || pop);
    count_nxt = count + (QW+1)'(push) - (QW+1)'(pop);
    rd_off = frame_base + PW'(disp_x);
    unused_rdata = ^ram_rdata[31:12];
  end
  always_ff @(posedge clock)
    if (push) fifo[tail[QW-1:0]] <= smp_data;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ram_addr <= '0;
      ram_we <= 1'b0;
      ram_wdata <= '0;
      disp_valid <= 1'b0;
      disp_data <= '0;
      fifo_full <= 1'b0;
      drop_count <= '0;
      head <= '0;
      tail <= '0;
      wr_ptr <= '0;
      frame_base <= '0;
      fill_count <= '0;
      frame_fill <= '0;
      {p1, p2, b1, b2} <= '0;
    end else begin
      ram_we <= pop;
      if (disp_req) ram_addr <= RING_BASE + ADDR_W'(rd_off);
      else if (pop) begin
        ram_addr <= RING_BASE + ADDR_W'(wr_ptr);
        ram_wdata <= {20'b0, fifo[head[QW-1:0]]};
        wr_ptr <= wr_ptr + 1'b1;
        fill_count <= fill_count == (PW+1)'(RING_LEN) ? fill_count : fill_count + 1'b1;
      end
      head <= head + (QW+1)'(pop);
      tail <= tail + (QW+1)'(push);
      fifo_full <= count_nxt == (QW+1)'(FIFO_DEPTH);
      if (smp_valid && !push && drop_count != '1) drop_count <= drop_count + 1'b1;
      // pre-edge wr_ptr/fill_count: a write issued on this edge belongs to the next frame
      if (screen_end && !freeze) begin
        frame_base <= fill_count < (PW+1)'(WINDOW) ? '0 : wr_ptr - PW'(WINDOW);
        frame_fill <= fill_count < (PW+1)'(WINDOW) ? FW'(fill_count) : FW'(WINDOW);
      end
      p1 <= disp_req;
      b1 <= int'(disp_x) >= int'(frame_fill);
      p2 <= p1;
      b2 <= b1;
      disp_valid <= p2;
      disp_data <= p2 && !b2 ? ram_rdata[11:0] : '0;
    end
  end
endmodule

// File: tb/tb_ecg_ram_scheduler.sv
// tb_ecg_ram_scheduler: directed literal scenarios plus random traffic against a queue-based reference model.
module tb_ecg_ram_scheduler;
  logic        clock = 1'b0, reset = 1'b0;
  logic        disp_req = 1'b0, screen_end = 1'b0, freeze = 1'b0, smp_valid = 1'b0;
  logic [9:0]  disp_x = '0;
  logic [11:0] smp_data = '0;
  logic [11:0] ram_addr;
  logic        ram_we, disp_valid, fifo_full;
  logic [31:0] ram_wdata, ram_rdata = '0;
  logic [11:0] disp_data;
  logic [15:0] drop_count;
  logic [31:0] mem [4096];
  int ncmp = 0, nfail = 0;

  ecg_ram_scheduler dut (
    .clock(clock), .reset(reset), .disp_req(disp_req), .disp_x(disp_x),
    .screen_end(screen_end), .freeze(freeze), .smp_valid(smp_valid), .smp_data(smp_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .disp_valid(disp_valid), .disp_data(disp_data), .fifo_full(fifo_full), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: unbounded write count, sample queue, per-slot ring contents.
  int ring [2048];
  int q[$];
  int nwr = 0, drops = 0, base = 0, ffill = 0, pre = 0, sz = 0, f = 0, w = 0;
  int e_addr = 0, e_wdata = 0, e_data = 0, pd1 = 0, pd2 = 0;
  bit e_we = 0, e_valid = 0, e_full = 0, pv1 = 0, pv2 = 0, mpop = 0;

  always @(posedge clock) begin
    if (!reset) begin
      q.delete();
      nwr = 0; drops = 0; base = 0; ffill = 0;
      e_addr = 0; e_wdata = 0; e_we = 0; e_valid = 0; e_data = 0; e_full = 0;
      pv1 = 0; pv2 = 0; pd1 = 0; pd2 = 0;
    end else begin
      sz = q.size();
      pre = nwr;
      mpop = !disp_req && sz > 0;
      e_valid = pv2; e_data = pd2;
      pv2 = pv1; pd2 = pd1;
      pv1 = disp_req;
      pd1 = (int'(disp_x) >= ffill) ? 0 : ring[(base + int'(disp_x)) % 2048];
      e_we = 0;
      if (disp_req) e_addr = 'h800 + (base + int'(disp_x)) % 2048;
      else if (mpop) begin
        w = q.pop_front();
        e_addr = 'h800 + nwr % 2048;
        e_we = 1;
        e_wdata = w;
        ring[nwr % 2048] = w;
        nwr++;
      end
      if (smp_valid) begin
        if (sz < 4 || mpop) q.push_back(int'(smp_data));
        else if (drops < 65535) drops++;
      end
      if (screen_end && !freeze) begin
        f = pre < 2048 ? pre : 2048;
        base = f < 640 ? 0 : (pre - 640) % 2048;
        ffill = f < 640 ? f : 640;
      end
      e_full = q.size() == 4;
    end
  end

  always @(posedge clock) begin
    #1;
    chk("m_we", int'(ram_we), int'(e_we));
    chk("m_addr", int'(ram_addr), e_addr);
    if (e_we) chk("m_wdata", int'(ram_wdata), e_wdata);
    chk("m_valid", int'(disp_valid), int'(e_valid));
    if (e_valid) chk("m_data", int'(disp_data), e_data);
    chk("m_full", int'(fifo_full), int'(e_full));
    chk("m_drop", int'(drop_count), drops);
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    {disp_req, screen_end, freeze, smp_valid} = '0;
    step(); step();
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_wdata", int'(ram_wdata), 0);
    chk("rst_valid", int'(disp_valid), 0);
    chk("rst_full", int'(fifo_full), 0);
    chk("rst_drop", int'(drop_count), 0);
    reset = 1'b1;
  endtask

  task automatic push_n(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      smp_valid = 1'b1;
      smp_data = 12'(i);
      step();
    end
    smp_valid = 1'b0;
    step(); step();
  endtask

  task automatic frame_edge(input bit frz);
    screen_end = 1'b1; freeze = frz;
    step();
    screen_end = 1'b0; freeze = 1'b0;
  endtask

  // two back-to-back reads, checking addresses on E0/E1 and data on E2/E3
  task automatic read2(input int x0, input int x1, input int a0, input int a1, input int d0, input int d1);
    disp_req = 1'b1; disp_x = 10'(x0);
    step();
    chk("rd_addr0", int'(ram_addr), a0);
    disp_x = 10'(x1);
    step();
    chk("rd_addr1", int'(ram_addr), a1);
    chk("rd_valid_early", int'(disp_valid), 0);
    disp_req = 1'b0;
    step();
    chk("rd_valid0", int'(disp_valid), 1);
    chk("rd_data0", int'(disp_data), d0);
    step();
    chk("rd_valid1", int'(disp_valid), 1);
    chk("rd_data1", int'(disp_data), d1);
    step();
    chk("rd_valid_end", int'(disp_valid), 0);
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_we", int'(ram_we), 0);
      chk("idle_drop", int'(drop_count), 0);
    end

    push_n(1, 700);
    frame_edge(1'b0);
    read2(0, 639, 'h800 + 60, 'h800 + 699, 61, 700);

    do_reset();
    push_n(1, 100);
    frame_edge(1'b0);
    read2(50, 200, 'h800 + 50, 'h800 + 200, 51, 0);

    do_reset();
    disp_req = 1'b1; disp_x = '0;
    for (int i = 1; i <= 6; i++) begin
      smp_valid = 1'b1; smp_data = 12'(10 + i);
      step();
      chk("starve_we", int'(ram_we), 0);
      if (i == 3) chk("full_after3", int'(fifo_full), 0);
      if (i == 4) chk("full_after4", int'(fifo_full), 1);
    end
    smp_valid = 1'b0;
    chk("drop2", int'(drop_count), 2);
    disp_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("drain_we", int'(ram_we), 1);
      chk("drain_data", int'(ram_wdata), 10 + k);
      chk("drain_addr", int'(ram_addr), 'h800 + k - 1);
    end
    chk("drain_full", int'(fifo_full), 0);
    step();
    chk("drain_done", int'(ram_we), 0);

    do_reset();
    push_n(1, 2100);
    frame_edge(1'b0);
    read2(639, 0, 'h800 + 51, 'h800 + 1460, 2100, 1461);
    push_n(2101, 2110);
    frame_edge(1'b1);
    read2(639, 0, 'h800 + 51, 'h800 + 1460, 2100, 1461);

    disp_req = 1'b1; disp_x = 10'd639;
    step();
    reset = 1'b0;
    #1;
    chk("midrst_valid", int'(disp_valid), 0);
    chk("midrst_addr", int'(ram_addr), 0);
    step();
    reset = 1'b1; disp_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_quiet", int'(disp_valid), 0);
    end
    read2(5, 6, 'h805, 'h806, 0, 0);

    for (int i = 0; i < 6000; i++) begin
      reset = ($urandom_range(0, 1499) != 0);
      disp_req = ((i % 800) < 500) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      disp_x = 10'($urandom_range(0, 639));
      smp_valid = ($urandom_range(0, 2) == 0);
      smp_data = 12'($urandom);
      screen_end = ($urandom_range(0, 59) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      step();
    end
    reset = 1'b1;
    {disp_req, screen_end, freeze, smp_valid} = '0;
    step(); step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
